wolfram_ca_engine: RTL and testbench

- Parametrised successor to the fixed 3-input Wolfram rule gates.
- Holds a WIDTH-cell one-dimensional elementary cellular automaton.
- Applies a runtime-programmable 8-bit rule to every cell in parallel, one generation per clock.
- Runs for a requested number of generations, with optional early stop at a fixed point.
- Sits behind a simple load/start/done handshake, so one engine replaces the family of fixed-rule modules.

---
 rtl/wolfram_ca_pkg.sv | 18 +
 rtl/wolfram_ca_next.sv | 25 ++
 rtl/wolfram_ca_engine.sv | 133 +++++++++++++
 tb/tb_wolfram_ca_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wolfram_ca_pkg.sv
// Shared types and helpers for the programmable elementary cellular automaton engine.
package wolfram_ca_pkg;

  localparam int unsigned RULE_W = 8;
  localparam int unsigned NBR_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  // Neighbourhood 3'b000 selects the rule MSB, 3'b111 the LSB.
  function automatic logic rule_lookup(input logic [RULE_W-1:0] rule,
                                       input logic [NBR_W-1:0]  idx);
    return rule[NBR_W'(RULE_W - 1) - idx];
  endfunction

endpackage

// File: rtl/wolfram_ca_next.sv
// Combinational next-generation evaluator: applies one rule to every cell in parallel.
module wolfram_ca_next
  import wolfram_ca_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]  state,
  input  logic [RULE_W-1:0] rule,
  input  logic              wrap,
  output logic [WIDTH-1:0]  nxt_c
);

  // Cells padded with their boundary neighbours: ext[i +: 3] is {L, C, R} of cell i.
  logic [WIDTH+1:0] ext;

  assign ext = {wrap & state[0], state, wrap & state[WIDTH-1]};

  always_comb begin
    nxt_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      nxt_c[i] = rule_lookup(rule, ext[i +: NBR_W]);
    end
  end

endmodule

// File: rtl/wolfram_ca_engine.sv
// Runtime-programmable elementary CA engine with load/start/done handshake and fixed-point early stop.
module wolfram_ca_engine
  import wolfram_ca_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  seed_i,
  input  logic              start_i,
  input  logic [RULE_W-1:0] rule_i,
  input  logic              wrap_i,
  input  logic [STEP_W-1:0] steps_i,
  input  logic              pause_i,
  output logic [WIDTH-1:0]  state_o,
  output logic [STEP_W-1:0] gen_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              stable_o
);

  fsm_e              fsm_q,    fsm_d;
  logic [WIDTH-1:0]  state_q,  state_d;
  logic [STEP_W-1:0] gen_q,    gen_d;
  logic [STEP_W-1:0] rem_q,    rem_d;
  logic [RULE_W-1:0] rule_q,   rule_d;
  logic              wrap_q,   wrap_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic              stable_q, stable_d;
  logic [WIDTH-1:0]  nxt_c;

  // Evaluated from the latched rule/boundary so mid-run input changes are invisible.
  wolfram_ca_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .state(state_q),
    .rule (rule_q),
    .wrap (wrap_q),
    .nxt_c(nxt_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      gen_q    <= '0;
      rem_q    <= '0;
      rule_q   <= '0;
      wrap_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      gen_q    <= gen_d;
      rem_q    <= rem_d;
      rule_q   <= rule_d;
      wrap_q   <= wrap_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    gen_d    = gen_q;
    rem_d    = rem_q;
    rule_d   = rule_q;
    wrap_d   = wrap_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    stable_d = stable_q;

    unique case (fsm_q)
      IDLE: begin
        // A load in the same cycle as a start wins; the start is dropped.
        if (load_i) begin
          state_d = seed_i;
          gen_d   = '0;
        end else if (start_i) begin
          rule_d   = rule_i;
          wrap_d   = wrap_i;
          rem_d    = steps_i;
          stable_d = 1'b0;
          if (steps_i == '0) begin
            done_d = 1'b1;
          end else begin
            fsm_d  = RUN;
            busy_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (!pause_i) begin
          if (nxt_c == state_q) begin
            stable_d = 1'b1;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            fsm_d    = IDLE;
          end else begin
            state_d = nxt_c;
            gen_d   = gen_q + STEP_W'(1);
            rem_d   = rem_q - STEP_W'(1);
            if (rem_q == STEP_W'(1)) begin
              done_d = 1'b1;
              busy_d = 1'b0;
              fsm_d  = IDLE;
            end
          end
        end
      end

      default: begin
        fsm_d  = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  assign state_o  = state_q;
  assign gen_o    = gen_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign stable_o = stable_q;

endmodule

// File: tb/tb_wolfram_ca_engine.sv
// Directed-vector bench for wolfram_ca_engine at WIDTH=8, STEP_W=8.
module tb_wolfram_ca_engine;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STEP_W = 8;

  logic              clk;
  logic              rst_n;
  logic              load_i;
  logic [WIDTH-1:0]  seed_i;
  logic              start_i;
  logic [7:0]        rule_i;
  logic              wrap_i;
  logic [STEP_W-1:0] steps_i;
  logic              pause_i;
  logic [WIDTH-1:0]  state_o;
  logic [STEP_W-1:0] gen_o;
  logic              busy_o;
  logic              done_o;
  logic              stable_o;

  int vecs;
  int errs;

  wolfram_ca_engine #(
    .WIDTH (WIDTH),
    .STEP_W(STEP_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_i),
    .seed_i  (seed_i),
    .start_i (start_i),
    .rule_i  (rule_i),
    .wrap_i  (wrap_i),
    .steps_i (steps_i),
    .pause_i (pause_i),
    .state_o (state_o),
    .gen_o   (gen_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .stable_o(stable_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed tuple: {state, gen, busy, done, stable}
  function automatic logic [18:0] obs();
    return {state_o, gen_o, busy_o, done_o, stable_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] seed);
    load_i = 1'b1;
    seed_i = seed;
    tick();
    load_i = 1'b0;
  endtask

  // Drive start for one edge; returns in cycle t+1.
  task automatic do_start(input logic [7:0] rule, input logic wrap, input logic [7:0] steps);
    start_i = 1'b1;
    rule_i  = rule;
    wrap_i  = wrap;
    steps_i = steps;
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #4;
    vecs++;
    if (obs() !== 19'h0) begin
      errs++;
      $display("FAIL reset: got %h expected %h", obs(), 19'h0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vecs++;
    if (obs() !== 19'h0) begin
      errs++;
      $display("FAIL reset_release: got %h expected %h", obs(), 19'h0);
    end
  endtask

  task automatic test_single_step();
    do_load(8'h01);
    vecs++;
    if (obs() !== {8'h01, 8'd0, 3'b000}) begin
      errs++;
      $display("FAIL load_01: got %h expected %h", obs(), {8'h01, 8'd0, 3'b000});
    end
    do_start(8'h1B, 1'b1, 8'd1);
    vecs++;
    if (obs() !== {8'h01, 8'd0, 3'b100}) begin
      errs++;
      $display("FAIL single_t1: got %h expected %h", obs(), {8'h01, 8'd0, 3'b100});
    end
    tick();
    vecs++;
    if (obs() !== {8'h80, 8'd1, 3'b010}) begin
      errs++;
      $display("FAIL single_t2: got %h expected %h", obs(), {8'h80, 8'd1, 3'b010});
    end
    tick();
    vecs++;
    if (done_o !== 1'b0) begin
      errs++;
      $display("FAIL single_done_pulse: got %b expected %b", done_o, 1'b0);
    end
  endtask

  task automatic test_null_boundary();
    do_load(8'h01);
    do_start(8'h1B, 1'b0, 8'd1);
    tick();
    vecs++;
    if (obs() !== {8'h00, 8'd1, 3'b010}) begin
      errs++;
      $display("FAIL null_boundary: got %h expected %h", obs(), {8'h00, 8'd1, 3'b010});
    end
    tick();
  endtask

  task automatic test_two_steps();
    do_load(8'h10);
    do_start(8'h5A, 1'b0, 8'd2);
    rule_i = 8'h00;
    wrap_i = 1'b1;
    vecs++;
    if (obs() !== {8'h10, 8'd0, 3'b100}) begin
      errs++;
      $display("FAIL two_t1: got %h expected %h", obs(), {8'h10, 8'd0, 3'b100});
    end
    tick();
    vecs++;
    if (obs() !== {8'h28, 8'd1, 3'b100}) begin
      errs++;
      $display("FAIL two_t2: got %h expected %h", obs(), {8'h28, 8'd1, 3'b100});
    end
    tick();
    vecs++;
    if (obs() !== {8'h44, 8'd2, 3'b010}) begin
      errs++;
      $display("FAIL two_t3: got %h expected %h", obs(), {8'h44, 8'd2, 3'b010});
    end
    tick();
    vecs++;
    if (obs() !== {8'h44, 8'd2, 3'b000}) begin
      errs++;
      $display("FAIL two_t4: got %h expected %h", obs(), {8'h44, 8'd2, 3'b000});
    end
  endtask

  task automatic test_fixed_point();
    do_load(8'h00);
    do_start(8'h1B, 1'b0, 8'd5);
    vecs++;
    if (busy_o !== 1'b1) begin
      errs++;
      $display("FAIL fixed_busy: got %b expected %b", busy_o, 1'b1);
    end
    tick();
    vecs++;
    if (obs() !== {8'h00, 8'd0, 3'b011}) begin
      errs++;
      $display("FAIL fixed_t2: got %h expected %h", obs(), {8'h00, 8'd0, 3'b011});
    end
    tick();
    vecs++;
    if (obs() !== {8'h00, 8'd0, 3'b001}) begin
      errs++;
      $display("FAIL fixed_hold: got %h expected %h", obs(), {8'h00, 8'd0, 3'b001});
    end
  endtask

  task automatic test_zero_steps();
    do_start(8'h1B, 1'b0, 8'd0);
    vecs++;
    if (obs() !== {8'h00, 8'd0, 3'b010}) begin
      errs++;
      $display("FAIL zero_t1: got %h expected %h", obs(), {8'h00, 8'd0, 3'b010});
    end
    tick();
    vecs++;
    if (obs() !== {8'h00, 8'd0, 3'b000}) begin
      errs++;
      $display("FAIL zero_t2: got %h expected %h", obs(), {8'h00, 8'd0, 3'b000});
    end
  endtask

  task automatic test_priority();
    load_i  = 1'b1;
    start_i = 1'b1;
    seed_i  = 8'hA5;
    rule_i  = 8'h5A;
    steps_i = 8'd3;
    tick();
    load_i  = 1'b0;
    start_i = 1'b0;
    vecs++;
    if (obs() !== {8'hA5, 8'd0, 3'b000}) begin
      errs++;
      $display("FAIL prio_t1: got %h expected %h", obs(), {8'hA5, 8'd0, 3'b000});
    end
    tick();
    vecs++;
    if (obs() !== {8'hA5, 8'd0, 3'b000}) begin
      errs++;
      $display("FAIL prio_t2: got %h expected %h", obs(), {8'hA5, 8'd0, 3'b000});
    end
  endtask

  task automatic test_pause();
    do_load(8'h10);
    do_start(8'h5A, 1'b0, 8'd2);
    tick();
    pause_i = 1'b1;
    load_i  = 1'b1;
    seed_i  = 8'hFF;
    start_i = 1'b1;
    rule_i  = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++;
      if (obs() !== {8'h28, 8'd1, 3'b100}) begin
        errs++;
        $display("FAIL pause_hold%0d: got %h expected %h", k, obs(), {8'h28, 8'd1, 3'b100});
      end
    end
    pause_i = 1'b0;
    load_i  = 1'b0;
    start_i = 1'b0;
    tick();
    vecs++;
    if (obs() !== {8'h44, 8'd2, 3'b010}) begin
      errs++;
      $display("FAIL pause_end: got %h expected %h", obs(), {8'h44, 8'd2, 3'b010});
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    do_load(8'h01);
    do_start(8'hCC, 1'b1, 8'd10);
    tick();
    tick();
    tick();
    vecs++;
    if (obs() !== {8'hFE, 8'd3, 3'b100}) begin
      errs++;
      $display("FAIL abort_pre: got %h expected %h", obs(), {8'hFE, 8'd3, 3'b100});
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (obs() !== 19'h0) begin
      errs++;
      $display("FAIL abort_async: got %h expected %h", obs(), 19'h0);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++;
      if (obs() !== 19'h0) begin
        errs++;
        $display("FAIL abort_quiet%0d: got %h expected %h", k, obs(), 19'h0);
      end
    end
    do_load(8'h3C);
    vecs++;
    if (obs() !== {8'h3C, 8'd0, 3'b000}) begin
      errs++;
      $display("FAIL abort_reload: got %h expected %h", obs(), {8'h3C, 8'd0, 3'b000});
    end
  endtask

  task automatic test_gen_wrap();
    int cyc;
    do_load(8'h0F);
    do_start(8'hCC, 1'b1, 8'd255);
    cyc = 1;
    while (!done_o && cyc < 400) begin
      tick();
      cyc++;
    end
    vecs++;
    if (cyc !== 256) begin
      errs++;
      $display("FAIL wrap_latency: got %0d expected %0d", cyc, 256);
    end
    vecs++;
    if (obs() !== {8'hF0, 8'd255, 3'b010}) begin
      errs++;
      $display("FAIL wrap_255: got %h expected %h", obs(), {8'hF0, 8'd255, 3'b010});
    end
    tick();
    do_start(8'hCC, 1'b1, 8'd1);
    tick();
    vecs++;
    if (obs() !== {8'h0F, 8'd0, 3'b010}) begin
      errs++;
      $display("FAIL wrap_zero: got %h expected %h", obs(), {8'h0F, 8'd0, 3'b010});
    end
  endtask

  initial begin
    vecs    = 0;
    errs    = 0;
    load_i  = 1'b0;
    seed_i  = '0;
    start_i = 1'b0;
    rule_i  = '0;
    wrap_i  = 1'b0;
    steps_i = '0;
    pause_i = 1'b0;
    test_reset();
    test_single_step();
    test_null_boundary();
    test_two_steps();
    test_fixed_point();
    test_zero_steps();
    test_priority();
    test_pause();
    test_reset_mid_run();
    test_gen_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
